sram_access_arbiter: RTL

- Shares the single Avalon SRAM slave port (21-bit word address, 16-bit data) between two requesters inside the audio core: the record path (writes ADC samples) and the playback path (reads samples for the DAC).
- Sequences each access as a single-cycle read or write command.
- Allows one outstanding read at a time, with fair round-robin arbitration and a read-timeout guard.

---
 rtl/sram_access_arbiter_if.sv | 39 +++
 rtl/sram_access_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter_if.sv
// Bundle of requester-side and Avalon-side signals for sram_access_arbiter.
//   slave  : arbiter view (takes requests and readdata, drives acks and strobes)
//   master : environment view (record/playback requesters plus the SRAM slave)
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 16
);
  logic              i_wr_req;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ack;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_ack;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_rd_err;
  logic [ADDR_W-1:0] address;
  logic [1:0]        byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
           readdata, readdatavalid,
    output o_wr_ack, o_rd_ack, o_rd_data, o_rd_valid, o_rd_err,
           address, byteenable, read, write, writedata
  );

  modport master (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
           readdata, readdatavalid,
    input  o_wr_ack, o_rd_ack, o_rd_data, o_rd_valid, o_rd_err,
           address, byteenable, read, write, writedata
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Shares one Avalon SRAM slave port between the record path (writes) and the
// playback path (reads). One command per grant, one outstanding read at most,
// round-robin on contention, read-timeout guard.
// Ports:
//   i_clk : system clock
//   i_rst : synchronous active-high reset
//   bus   : sram_access_arbiter_if.slave (requester handshakes + Avalon master)
module sram_access_arbiter #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 16,
  parameter int RD_TIMEOUT = 16
) (
  input logic                  i_clk,
  input logic                  i_rst,
  sram_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT_RD} state_t;

  localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

  state_t            state, state_d;
  logic              last_rd, last_rd_d;   // 1: last grant went to the read side
  logic [7:0]        cnt, cnt_d;

  logic [ADDR_W-1:0] address_q, address_d;
  logic [1:0]        byteenable_q, byteenable_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;

  always_comb begin
    state_d    = state;
    last_rd_d  = last_rd;
    cnt_d      = cnt;
    address_d  = address_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_wr_req && (!bus.i_rd_req || last_rd)) begin
          state_d   = WRITE;
          last_rd_d = 1'b0;
          address_d = bus.i_wr_addr;
        end else if (bus.i_rd_req) begin
          state_d   = READ;
          last_rd_d = 1'b1;
          address_d = bus.i_rd_addr;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        cnt_d = '0;
        if (bus.readdatavalid) begin
          rd_data_d  = bus.readdata;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // Returned data takes priority over a timeout in the same cycle.
        if (bus.readdatavalid) begin
          rd_data_d  = bus.readdata;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (cnt == TO_LAST) begin
          rd_data_d  = '0;
          rd_valid_d = 1'b1;
          rd_err_d   = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they register alongside it.
    write_d      = (state_d == WRITE);
    wr_ack_d     = (state_d == WRITE);
    read_d       = (state_d == READ);
    rd_ack_d     = (state_d == READ);
    byteenable_d = (state_d != IDLE) ? 2'b11 : 2'b00;
    writedata_d  = (state_d == WRITE) ? bus.i_wr_data : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      last_rd      <= 1'b1;
      cnt          <= '0;
      address_q    <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      rd_data_q    <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state        <= state_d;
      last_rd      <= last_rd_d;
      cnt          <= cnt_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      rd_data_q    <= rd_data_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign bus.address    = address_q;
  assign bus.byteenable = byteenable_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_wr_ack   = wr_ack_q;
  assign bus.o_rd_ack   = rd_ack_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_err   = rd_err_q;

endmodule
